// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : generic_bus_if
// Purpose  : Simple request/busy memory bus shared by the cache complex and
//            the bus controller. An initiator holds ren or wen with addr,
//            wdata and byte_en stable. The responder lowers busy for the
//            cycle in which the access completes, and rdata is valid then.
// Signals  : addr[31:0], wdata[31:0], rdata[31:0], ren, wen, busy,
//            byte_en[3:0]
// Modports : generic_bus - responder view (request in, rdata/busy out)
//            cpu         - initiator view (request out, rdata/busy in)
// Revision : 1.0 - initial release
// ============================================================================
interface generic_bus_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ren;
   logic        wen;
   logic        busy;
   logic [3:0]  byte_en;

   modport generic_bus (
      input  addr, wdata, ren, wen, byte_en,
      output rdata, busy
   );

   modport cpu (
      output addr, wdata, ren, wen, byte_en,
      input  rdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Memory-side responder for the icache, dcache and page-walker
//            buses. It picks one pending request, latches it and replays it
//            on the single downstream initiator bus. It returns completion
//            and rdata only to the requester that owns the grant. Every
//            transaction is followed by one idle bubble cycle (DONE).
// Ports    : CLK               - clock, rising edge
//            RST               - asynchronous active-high reset
//            icache_gen_bus_if - icache requests (responder side)
//            dcache_gen_bus_if - dcache requests (responder side)
//            pw_gen_bus_if     - page-walker requests (responder side)
//            mem_gen_bus_if    - downstream initiator to the bus controller
//            grant[1:0]        - owner: 0 none, 1 pw, 2 dcache, 3 icache
//            arb_active        - high while a downstream access is in flight
// Params   : STARVE_LIMIT - consecutive lost arbitrations after which a
//                           pending icache request wins (0 disables)
//            RESET_ADDR   - downstream addr at reset and while idle
// Options  : MEM_BUS_ARB_RR_EN - when defined, round-robin arbitration
//                                replaces fixed priority and the starvation
//                                override is removed
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [31:0] RESET_ADDR   = 32'h0
) (
   input  logic               CLK,
   input  logic               RST,
   generic_bus_if.generic_bus icache_gen_bus_if,
   generic_bus_if.generic_bus dcache_gen_bus_if,
   generic_bus_if.generic_bus pw_gen_bus_if,
   generic_bus_if.cpu         mem_gen_bus_if,
   output logic [1:0]         grant,
   output logic               arb_active
);

   localparam logic [1:0] c_gnt_none = 2'd0;
   localparam logic [1:0] c_gnt_pw   = 2'd1;
   localparam logic [1:0] c_gnt_dc   = 2'd2;
   localparam logic [1:0] c_gnt_ic   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_ren;
   logic        r_wen;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_byte_en;

   logic        w_pend_pw;
   logic        w_pend_dc;
   logic        w_pend_ic;
   logic [1:0]  w_win;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic [3:0]  w_sel_byte_en;
   logic        w_sel_wen;
   logic        w_in_xfer;
   logic        w_xfer_done;

   // A requester is pending on either strobe; a write strobe dominates.
   assign w_pend_pw = pw_gen_bus_if.ren     | pw_gen_bus_if.wen;
   assign w_pend_dc = dcache_gen_bus_if.ren | dcache_gen_bus_if.wen;
   assign w_pend_ic = icache_gen_bus_if.ren | icache_gen_bus_if.wen;

   // -------------------------------------------------------------------------
   // Winner selection
   // -------------------------------------------------------------------------
`ifdef MEM_BUS_ARB_RR_EN
   // Last granted port; the search starts at the port after it in the ring
   // pw -> dcache -> icache -> pw. Resetting to icache makes pw win first.
   logic [1:0] r_last;

   always_comb begin
      w_win = c_gnt_none;
      case (r_last)
         c_gnt_pw: begin
            if (w_pend_dc)      w_win = c_gnt_dc;
            else if (w_pend_ic) w_win = c_gnt_ic;
            else if (w_pend_pw) w_win = c_gnt_pw;
         end
         c_gnt_dc: begin
            if (w_pend_ic)      w_win = c_gnt_ic;
            else if (w_pend_pw) w_win = c_gnt_pw;
            else if (w_pend_dc) w_win = c_gnt_dc;
         end
         default: begin
            if (w_pend_pw)      w_win = c_gnt_pw;
            else if (w_pend_dc) w_win = c_gnt_dc;
            else if (w_pend_ic) w_win = c_gnt_ic;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_last <= c_gnt_ic;
      end else if (r_state == ST_IDLE && w_win != c_gnt_none) begin
         r_last <= w_win;
      end
   end
`else
   localparam int unsigned c_starve_w   = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam bit          c_starve_en  = (STARVE_LIMIT != 0);
   localparam logic [c_starve_w-1:0] c_starve_lim = c_starve_w'(STARVE_LIMIT);

   logic [c_starve_w-1:0] r_starve_cnt;
   logic                  w_starve_hit;

   assign w_starve_hit = c_starve_en && w_pend_ic && (r_starve_cnt >= c_starve_lim);

   always_comb begin
      w_win = c_gnt_none;
      if (w_starve_hit)   w_win = c_gnt_ic;
      else if (w_pend_pw) w_win = c_gnt_pw;
      else if (w_pend_dc) w_win = c_gnt_dc;
      else if (w_pend_ic) w_win = c_gnt_ic;
   end

   // Counts grants that went elsewhere while icache was waiting. Any grant
   // that finds icache idle, or that goes to icache, restarts the count.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_starve_cnt <= '0;
      end else if (c_starve_en && r_state == ST_IDLE && w_win != c_gnt_none) begin
         if (w_win != c_gnt_ic && w_pend_ic) begin
            if (r_starve_cnt < c_starve_lim) begin
               r_starve_cnt <= r_starve_cnt + 1'b1;
            end
         end else begin
            r_starve_cnt <= '0;
         end
      end
   end
`endif

   // Request fields of the winner, captured on the IDLE -> XFER edge.
   always_comb begin
      w_sel_addr    = '0;
      w_sel_wdata   = '0;
      w_sel_byte_en = '0;
      w_sel_wen     = 1'b0;
      case (w_win)
         c_gnt_pw: begin
            w_sel_addr    = pw_gen_bus_if.addr;
            w_sel_wdata   = pw_gen_bus_if.wdata;
            w_sel_byte_en = pw_gen_bus_if.byte_en;
            w_sel_wen     = pw_gen_bus_if.wen;
         end
         c_gnt_dc: begin
            w_sel_addr    = dcache_gen_bus_if.addr;
            w_sel_wdata   = dcache_gen_bus_if.wdata;
            w_sel_byte_en = dcache_gen_bus_if.byte_en;
            w_sel_wen     = dcache_gen_bus_if.wen;
         end
         c_gnt_ic: begin
            w_sel_addr    = icache_gen_bus_if.addr;
            w_sel_wdata   = icache_gen_bus_if.wdata;
            w_sel_byte_en = icache_gen_bus_if.byte_en;
            w_sel_wen     = icache_gen_bus_if.wen;
         end
         default: begin
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Transaction FSM. Downstream request lines come only from the latched
   // copies, so upstream changes during XFER never reach the bus controller.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         grant      <= c_gnt_none;
         arb_active <= 1'b0;
         r_ren      <= 1'b0;
         r_wen      <= 1'b0;
         r_addr     <= RESET_ADDR;
         r_wdata    <= '0;
         r_byte_en  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_win != c_gnt_none) begin
                  r_state    <= ST_XFER;
                  grant      <= w_win;
                  arb_active <= 1'b1;
                  r_wen      <= w_sel_wen;
                  r_ren      <= ~w_sel_wen;
                  r_addr     <= w_sel_addr;
                  r_wdata    <= w_sel_wdata;
                  r_byte_en  <= w_sel_byte_en;
               end
            end
            ST_XFER: begin
               if (!mem_gen_bus_if.busy) begin
                  r_state    <= ST_DONE;
                  grant      <= c_gnt_none;
                  arb_active <= 1'b0;
                  r_ren      <= 1'b0;
                  r_wen      <= 1'b0;
                  r_addr     <= RESET_ADDR;
                  r_wdata    <= '0;
                  r_byte_en  <= '0;
               end
            end
            // Bubble: a requester still holding its strobe for one cycle
            // after completion is not seen as a new request.
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_gen_bus_if.ren     = r_ren;
   assign mem_gen_bus_if.wen     = r_wen;
   assign mem_gen_bus_if.addr    = r_addr;
   assign mem_gen_bus_if.wdata   = r_wdata;
   assign mem_gen_bus_if.byte_en = r_byte_en;

   // Completion is forwarded combinationally, only to the owner.
   assign w_in_xfer   = (r_state == ST_XFER);
   assign w_xfer_done = w_in_xfer & ~mem_gen_bus_if.busy;

   assign pw_gen_bus_if.busy     = ~(w_xfer_done && grant == c_gnt_pw);
   assign dcache_gen_bus_if.busy = ~(w_xfer_done && grant == c_gnt_dc);
   assign icache_gen_bus_if.busy = ~(w_xfer_done && grant == c_gnt_ic);

   assign pw_gen_bus_if.rdata     = (w_in_xfer && grant == c_gnt_pw) ? mem_gen_bus_if.rdata : '0;
   assign dcache_gen_bus_if.rdata = (w_in_xfer && grant == c_gnt_dc) ? mem_gen_bus_if.rdata : '0;
   assign icache_gen_bus_if.rdata = (w_in_xfer && grant == c_gnt_ic) ? mem_gen_bus_if.rdata : '0;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Memory-side responder for the three initiator buses that the separate I$/D$/page-walker cache complex drives.
- It accepts requests on three generic_bus_if responder ports: icache, dcache and page walker.
- It picks one request per transaction, latches it, and forwards it as initiator on a single downstream generic_bus_if toward the bus controller.
- It returns rdata and completion to the granted requester only.

Parameters:
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending icache request is granted ahead of everyone; 0 disables the starvation override.
RESET_ADDR, 32'h0, value driven on downstream addr at reset and while IDLE.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
icache_gen_bus_if  modport generic_bus  if  icache-side requests (addr, wdata, ren, wen, byte_en in; rdata, busy out)
dcache_gen_bus_if  modport generic_bus  if  dcache-side requests
pw_gen_bus_if  modport generic_bus  if  page-walker requests
mem_gen_bus_if  modport cpu  if  downstream initiator to the bus controller
grant  output  2  current owner: 0 none, 1 pw, 2 dcache, 3 icache
arb_active  output  1  high while a downstream transaction is in flight

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, grant=0, arb_active=0.
  - Downstream ren=wen=0, addr=RESET_ADDR, wdata=0, byte_en=0.
  - All upstream busy=1, starve counter=0.
- States: IDLE, XFER, DONE.
- IDLE:
  - A requester is pending when ren|wen=1.
  - Fixed priority: pw > dcache > icache, except when starve_cnt>=STARVE_LIMIT and STARVE_LIMIT!=0, where a pending icache wins.
  - On any pending request: latch winner's addr, wdata, byte_en, op; set grant; go to XFER next edge.
  - If a requester asserts both ren and wen, it is treated as a write (wen wins, ren ignored).
- XFER:
  - Downstream ren/wen/addr/wdata/byte_en are driven from latched copies only, so upstream changes during XFER are ignored. arb_active=1.
  - When downstream busy=0, the granted requester sees busy=0 in the same cycle, and rdata passes combinationally from downstream. Then go to DONE.
- DONE:
  - One bubble cycle. Downstream ren=wen=0, all busy=1, grant=0. Next state is IDLE.
  - The bubble ensures a requester that holds ren for one extra cycle is not re-serviced.
- Non-granted requesters see busy=1 and rdata=0 at all times.
- Minimum latency: request seen in cycle N, downstream request asserted in N+1, completion no earlier than N+1 with a zero-wait downstream, next grant no earlier than N+3.
- Starve counter (only when STARVE_LIMIT!=0):
  - Increments, saturating, on each IDLE→XFER grant to pw/dcache while icache is pending.
  - Cleared on an icache grant, or when icache is not pending at grant time.
- Requester withdraws during XFER: the transaction still completes downstream. If the requester has dropped ren/wen, the busy=0 pulse is still issued and the requester ignores it. No cancellation exists.
- Reset mid-XFER: abort immediately to the reset values. Downstream is reset by the same RST, so no handshake is left dangling.
- addr/wdata width is word_t. byte_en is passed through unmodified.

Optional Feature:
MEM_BUS_ARB_RR_EN
- Defined: the fixed priority becomes round-robin among pending requesters. The starting point is the port after the last granted one, in the order pw→dcache→icache→pw. The last-granted pointer resets to icache, so pw wins first. STARVE_LIMIT logic is removed.
- Undefined: fixed priority plus starvation override as above.

Test Plan:
- Single dcache read: addr=0x100, downstream busy low 2 cycles after request → dcache busy=0 for 1 cycle with rdata=0xDEADBEEF; icache/pw busy stay 1; grant 2→0.
- Simultaneous ren from pw (0x8000), dcache (0x200) and icache (0x0) → service order pw, dcache, icache; each downstream addr matches; every transaction separated by one DONE bubble.
- Starvation, STARVE_LIMIT=2, icache pending continuously and dcache re-requesting every IDLE → dcache, dcache, icache; then starve_cnt=0.
- Upstream addr changed 0x40→0x44 mid-XFER → downstream addr stays 0x40 until completion.
- Write with ren=wen=1, wdata=0x12345678, byte_en=4'b0011 → downstream wen=1, ren=0, wdata and byte_en forwarded exactly.
- RST asserted mid-XFER (async, between edges) → downstream ren/wen drop immediately; after release all busy=1, grant=0, the next request is arbitrated fresh.
- With MEM_BUS_ARB_RR_EN, all three pending continuously → grant sequence 1,2,3,1,2,3.
